id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage MIPS core. Sits directly downstream of the register file.
//  - Captures RSdata/RTdata, immediate and decoded control each cycle.
//  - Bypasses same-cycle WB writes into the captured operands.
//  - Detects load-use hazards and inserts bubbles. Honours branch flush and global hold.
//  - Keeps a saturating count of load-use bubbles.

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures operands, immediate and decoded control
// from the decode stage, merges same-cycle write-back data into the operands,
// and turns load-use pairs, branch flushes and global holds into bubbles or freezes.
module id_ex_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               hold_i,
   input  logic               flush_i,
   input  logic               id_valid_i,
   input  logic [DATA_W-1:0]  id_pc_i,
   input  logic [ADDR_W-1:0]  RSaddr_i,
   input  logic [ADDR_W-1:0]  RTaddr_i,
   input  logic [ADDR_W-1:0]  RDaddr_i,
   input  logic [DATA_W-1:0]  RSdata_i,
   input  logic [DATA_W-1:0]  RTdata_i,
   input  logic [DATA_W-1:0]  imm_i,
   input  logic               RegWrite_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic               MemtoReg_i,
   input  logic               ALUSrc_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic               wb_RegWrite_i,
   input  logic [ADDR_W-1:0]  wb_RDaddr_i,
   input  logic [DATA_W-1:0]  wb_RDdata_i,
   output logic               ex_valid_o,
   output logic [DATA_W-1:0]  ex_pc_o,
   output logic [ADDR_W-1:0]  ex_RSaddr_o,
   output logic [ADDR_W-1:0]  ex_RTaddr_o,
   output logic [ADDR_W-1:0]  ex_RDaddr_o,
   output logic [DATA_W-1:0]  ex_RSdata_o,
   output logic [DATA_W-1:0]  ex_RTdata_o,
   output logic [DATA_W-1:0]  ex_imm_o,
   output logic               ex_RegWrite_o,
   output logic               ex_MemRead_o,
   output logic               ex_MemWrite_o,
   output logic               ex_MemtoReg_o,
   output logic               ex_ALUSrc_o,
   output logic [ALUOP_W-1:0] ex_ALUOp_o,
   output logic               stall_o,
   output logic [CNT_W-1:0]   bubble_cnt_o
);

   logic              haz;
   logic              kill;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;

   // Load in EX whose destination is read by ID; rt is compared even when unused.
   always_comb begin
      haz = ex_valid_o & ex_MemRead_o & (ex_RDaddr_o != '0) & id_valid_i &
            ((ex_RDaddr_o == RSaddr_i) | (ex_RDaddr_o == RTaddr_i));
   end

   assign stall_o = haz & ~flush_i & ~hold_i;
   assign kill    = ~hold_i & (flush_i | haz);

   // Merge a same-cycle write-back into the operands; $0 is never forwarded.
   always_comb begin
      rs_data = RSdata_i;
      rt_data = RTdata_i;
      if (wb_RegWrite_i && (wb_RDaddr_i != '0) && (wb_RDaddr_i == RSaddr_i)) begin
         rs_data = wb_RDdata_i;
      end
      if (wb_RegWrite_i && (wb_RDaddr_i != '0) && (wb_RDaddr_i == RTaddr_i)) begin
         rt_data = wb_RDdata_i;
      end
   end

   // Pipeline register: reset and bubbles clear everything, hold freezes, else capture.
   always_ff @(posedge clk_i) begin
      if (rst_i || kill) begin
         ex_valid_o    <= 1'b0;
         ex_pc_o       <= '0;
         ex_RSaddr_o   <= '0;
         ex_RTaddr_o   <= '0;
         ex_RDaddr_o   <= '0;
         ex_RSdata_o   <= '0;
         ex_RTdata_o   <= '0;
         ex_imm_o      <= '0;
         ex_RegWrite_o <= 1'b0;
         ex_MemRead_o  <= 1'b0;
         ex_MemWrite_o <= 1'b0;
         ex_MemtoReg_o <= 1'b0;
         ex_ALUSrc_o   <= 1'b0;
         ex_ALUOp_o    <= '0;
      end else if (!hold_i) begin
         ex_valid_o    <= id_valid_i;
         ex_pc_o       <= id_pc_i;
         ex_RSaddr_o   <= RSaddr_i;
         ex_RTaddr_o   <= RTaddr_i;
         ex_RDaddr_o   <= RDaddr_i;
         ex_RSdata_o   <= rs_data;
         ex_RTdata_o   <= rt_data;
         ex_imm_o      <= imm_i;
         ex_RegWrite_o <= RegWrite_i & id_valid_i;
         ex_MemRead_o  <= MemRead_i & id_valid_i;
         ex_MemWrite_o <= MemWrite_i & id_valid_i;
         ex_MemtoReg_o <= MemtoReg_i & id_valid_i;
         ex_ALUSrc_o   <= ALUSrc_i & id_valid_i;
         ex_ALUOp_o    <= id_valid_i ? ALUOp_i : '0;
      end
   end

   // Saturating count of load-use bubbles; flush-induced bubbles are not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bubble_cnt_o <= '0;
      end else if (stall_o && (bubble_cnt_o != '1)) begin
         bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
